// File: rtl/wb_forward_pipe_if.sv
// Bus bundle for the write-back pipeline.
// Groups the decoded-instruction inputs, the bypass query ports and the GRF write port.
interface wb_forward_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NQ     = 2
);
  // Decoded instruction entering E
  logic                   in_valid;
  logic                   stall;
  logic                   flush;
  logic [2:0]             reg_dst;
  logic [2:0]             wsel;
  logic [ADDR_W-1:0]      rt;
  logic [ADDR_W-1:0]      rd;
  logic [DATA_W-1:0]      pc;

  // Late results from the datapath
  logic [DATA_W-1:0]      alu_res;
  logic [DATA_W-1:0]      load_data;

  // Bypass query ports
  logic [NQ*ADDR_W-1:0]   q_addr;
  logic [NQ*DATA_W-1:0]   q_data;
  logic [NQ-1:0]          q_fwd;
  logic [NQ-1:0]          q_wait;

  // GRF write port
  logic                   rf_we;
  logic [ADDR_W-1:0]      rf_waddr;
  logic [DATA_W-1:0]      rf_wdata;

  modport master (
    output in_valid, stall, flush, reg_dst, wsel, rt, rd, pc,
    output alu_res, load_data, q_addr,
    input  q_data, q_fwd, q_wait, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  in_valid, stall, flush, reg_dst, wsel, rt, rd, pc,
    input  alu_res, load_data, q_addr,
    output q_data, q_fwd, q_wait, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/wb_forward_pipe.sv
// Write-back pipeline E -> M -> W for the pipelined MIPS datapath.
// Carries destination address and result data per instruction, captures the
// result in the stage that produces it, drives the GRF write port from W and
// offers a combinational bypass network (forward / wait) per query port.
module wb_forward_pipe #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31,
  parameter int LINK_OFF = 8,
  parameter int NQ       = 2
) (
  input  logic              clk,
  input  logic              reset,
  wb_forward_pipe_if.slave  bus
);

  localparam logic [2:0] SEL_ALU  = 3'd0;
  localparam logic [2:0] SEL_LOAD = 3'd1;
  localparam logic [2:0] SEL_LINK = 3'd2;

  // ---------------------------------------------------------------------------
  // Stage registers. W keeps no sel field: nothing downstream of W consumes it.
  // ---------------------------------------------------------------------------
  logic              e_v_q,    e_v_d;
  logic [ADDR_W-1:0] e_addr_q, e_addr_d;
  logic [2:0]        e_sel_q,  e_sel_d;
  logic [DATA_W-1:0] e_data_q, e_data_d;
  logic              e_rdy_q,  e_rdy_d;

  logic              m_v_q,    m_v_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [2:0]        m_sel_q,  m_sel_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_rdy_q,  m_rdy_d;

  logic              w_v_q,    w_v_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              w_rdy_q,  w_rdy_d;

  // A stage writes only when it holds an instruction with a nonzero target.
  logic e_wr, m_wr, w_wr;
  assign e_wr = e_v_q && (e_addr_q != '0);
  assign m_wr = m_v_q && (m_addr_q != '0);
  assign w_wr = w_v_q && (w_addr_q != '0);

  // E entry: decode destination and pre-compute the link value, which is ready at once.
  always_comb begin
    e_v_d    = 1'b0;
    e_addr_d = '0;
    e_sel_d  = '0;
    e_data_d = '0;
    e_rdy_d  = 1'b0;
    if (bus.in_valid && !bus.stall) begin
      e_v_d   = 1'b1;
      e_sel_d = bus.wsel;
      case (bus.reg_dst)
        3'd0:    e_addr_d = bus.rt;
        3'd1:    e_addr_d = bus.rd;
        3'd2:    e_addr_d = ADDR_W'(LINK_REG);
        default: e_addr_d = '0;
      endcase
      // wsel 3..7 means the instruction has no result to write.
      if (bus.wsel > SEL_LINK) begin
        e_addr_d = '0;
      end
      if (bus.wsel == SEL_LINK) begin
        e_data_d = bus.pc + DATA_W'(LINK_OFF);
        e_rdy_d  = 1'b1;
      end
    end
  end

  // E -> M: flush turns M into a bubble; ALU results are captured on the way in.
  always_comb begin
    m_v_d    = 1'b0;
    m_addr_d = '0;
    m_sel_d  = '0;
    m_data_d = '0;
    m_rdy_d  = 1'b0;
    if (!bus.flush && e_v_q) begin
      m_v_d    = 1'b1;
      m_addr_d = e_addr_q;
      m_sel_d  = e_sel_q;
      m_data_d = e_data_q;
      m_rdy_d  = e_rdy_q;
      if (e_sel_q == SEL_ALU) begin
        m_data_d = bus.alu_res;
        m_rdy_d  = 1'b1;
      end
    end
  end

  // M -> W: load data is captured on the way in, so it is only ever seen from W.
  always_comb begin
    w_v_d    = 1'b0;
    w_addr_d = '0;
    w_data_d = '0;
    w_rdy_d  = 1'b0;
    if (m_v_q) begin
      w_v_d    = 1'b1;
      w_addr_d = m_addr_q;
      w_data_d = m_data_q;
      w_rdy_d  = m_rdy_q;
      if (m_sel_q == SEL_LOAD) begin
        w_data_d = bus.load_data;
        w_rdy_d  = 1'b1;
      end
    end
  end

  // Stage register update; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_v_q    <= 1'b0;
      e_addr_q <= '0;
      e_sel_q  <= '0;
      e_data_q <= '0;
      e_rdy_q  <= 1'b0;
      m_v_q    <= 1'b0;
      m_addr_q <= '0;
      m_sel_q  <= '0;
      m_data_q <= '0;
      m_rdy_q  <= 1'b0;
      w_v_q    <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      w_rdy_q  <= 1'b0;
    end else begin
      e_v_q    <= e_v_d;
      e_addr_q <= e_addr_d;
      e_sel_q  <= e_sel_d;
      e_data_q <= e_data_d;
      e_rdy_q  <= e_rdy_d;
      m_v_q    <= m_v_d;
      m_addr_q <= m_addr_d;
      m_sel_q  <= m_sel_d;
      m_data_q <= m_data_d;
      m_rdy_q  <= m_rdy_d;
      w_v_q    <= w_v_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      w_rdy_q  <= w_rdy_d;
    end
  end

  // GRF write port straight from W, forced to zero when W does not write.
  assign bus.rf_we    = w_wr;
  assign bus.rf_waddr = w_wr ? w_addr_q : '0;
  assign bus.rf_wdata = w_wr ? w_data_q : '0;

  // ---------------------------------------------------------------------------
  // Bypass network: one independent search per query port.
  // ---------------------------------------------------------------------------
  logic [NQ-1:0]        q_fwd_c;
  logic [NQ-1:0]        q_wait_c;
  logic [NQ*DATA_W-1:0] q_data_c;

  genvar gi;
  generate
    for (gi = 0; gi < NQ; gi++) begin : g_query
      logic [ADDR_W-1:0] qa;
      logic              fwd;
      logic              wt;
      logic [DATA_W-1:0] dat;

      assign qa = bus.q_addr[gi*ADDR_W +: ADDR_W];

      // Youngest writing match wins; a not-ready youngest match blocks older ready ones.
      always_comb begin
        fwd = 1'b0;
        wt  = 1'b0;
        dat = '0;
        if (qa != '0) begin
          if (e_wr && (e_addr_q == qa)) begin
            fwd = e_rdy_q;
            wt  = !e_rdy_q;
            dat = e_rdy_q ? e_data_q : '0;
          end else if (m_wr && (m_addr_q == qa)) begin
            fwd = m_rdy_q;
            wt  = !m_rdy_q;
            dat = m_rdy_q ? m_data_q : '0;
          end else if (w_wr && (w_addr_q == qa)) begin
            fwd = w_rdy_q;
            wt  = !w_rdy_q;
            dat = w_rdy_q ? w_data_q : '0;
          end
        end
      end

      assign q_fwd_c[gi]                    = fwd;
      assign q_wait_c[gi]                   = wt;
      assign q_data_c[gi*DATA_W +: DATA_W]  = dat;
    end
  endgenerate

  assign bus.q_fwd  = q_fwd_c;
  assign bus.q_wait = q_wait_c;
  assign bus.q_data = q_data_c;

endmodule

// File: tb/tb_wb_forward_pipe.sv
// Directed bench for wb_forward_pipe with a decoupled scoreboard: stimulus
// pushes expected GRF writes and bypass answers, a negedge monitor pops and checks.
module tb_wb_forward_pipe;

  logic clk;
  logic reset;

  wb_forward_pipe_if #(.DATA_W(32), .ADDR_W(5), .NQ(2)) bus ();

  wb_forward_pipe #(
    .DATA_W(32), .ADDR_W(5), .LINK_REG(31), .LINK_OFF(8), .NQ(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_exp_t;

  typedef struct {
    int          port;
    logic        fwd;
    logic        wt;
    logic [31:0] data;
    string       name;
  } q_exp_t;

  wr_exp_t rf_q[$];
  q_exp_t  qx_q[$];
  int      n_checks = 0;
  int      n_fails  = 0;
  logic    mon_en   = 1'b0;

  // Monitor: every cycle check the GRF port, then drain all pending query expectations.
  always begin
    @(negedge clk);
    if (mon_en) begin
      n_checks++;
      if (bus.rf_we) begin
        if (rf_q.size() == 0) begin
          n_fails++;
          $display("FAIL rf_unexpected: got we=1 addr=%0d data=%h, required no write",
                   bus.rf_waddr, bus.rf_wdata);
        end else begin
          wr_exp_t e;
          e = rf_q.pop_front();
          if (bus.rf_waddr !== e.addr || bus.rf_wdata !== e.data) begin
            n_fails++;
            $display("FAIL rf_write: got addr=%0d data=%h, required addr=%0d data=%h",
                     bus.rf_waddr, bus.rf_wdata, e.addr, e.data);
          end else begin
            $display("ok   rf_write addr=%0d data=%h", e.addr, e.data);
          end
        end
      end else if (bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'd0) begin
        n_fails++;
        $display("FAIL rf_idle: got we=%b addr=%0d data=%h, required all zero",
                 bus.rf_we, bus.rf_waddr, bus.rf_wdata);
      end
      while (qx_q.size() > 0) begin
        q_exp_t      x;
        logic        gf;
        logic        gw;
        logic [31:0] gd;
        x  = qx_q.pop_front();
        gf = bus.q_fwd[x.port];
        gw = bus.q_wait[x.port];
        gd = bus.q_data[x.port*32 +: 32];
        n_checks++;
        if (gf !== x.fwd || gw !== x.wt || gd !== x.data) begin
          n_fails++;
          $display("FAIL %s: port %0d got fwd=%b wait=%b data=%h, required fwd=%b wait=%b data=%h",
                   x.name, x.port, gf, gw, gd, x.fwd, x.wt, x.data);
        end else begin
          $display("ok   %s: port %0d fwd=%b wait=%b data=%h", x.name, x.port, gf, gw, gd);
        end
      end
    end
  end

  // Advance one cycle; decode controls default to idle afterwards.
  task automatic cyc();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic issue(input logic [2:0] rdst, input logic [2:0] ws,
                       input logic [4:0] rt_i, input logic [4:0] rd_i,
                       input logic [31:0] pc_i);
    bus.in_valid = 1'b1;
    bus.reg_dst  = rdst;
    bus.wsel     = ws;
    bus.rt       = rt_i;
    bus.rd       = rd_i;
    bus.pc       = pc_i;
  endtask

  task automatic exp_wr(input logic [4:0] a, input logic [31:0] d);
    wr_exp_t e;
    e.addr = a;
    e.data = d;
    rf_q.push_back(e);
  endtask

  task automatic query(input int port, input logic [4:0] a, input logic f,
                       input logic w, input logic [31:0] d, input string nm);
    q_exp_t x;
    bus.q_addr[port*5 +: 5] = a;
    x.port = port;
    x.fwd  = f;
    x.wt   = w;
    x.data = d;
    x.name = nm;
    qx_q.push_back(x);
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
    bus.reg_dst   = 3'd0;
    bus.wsel      = 3'd2;
    bus.rt        = 5'd3;
    bus.rd        = 5'd0;
    bus.pc        = 32'h100;
    bus.alu_res   = 32'h0;
    bus.load_data = 32'h0;
    bus.q_addr    = '0;

    // Reset held across two edges with a valid link instruction offered.
    cyc();                                  // C1
    mon_en = 1'b1;
    issue(3'd0, 3'd2, 5'd3, 5'd0, 32'h100);
    query(0, 5'd3, 1'b0, 1'b0, 32'h0, "reset_q3_c1");
    cyc();                                  // C2
    reset = 1'b0;
    query(0, 5'd3, 1'b0, 1'b0, 32'h0, "reset_q3_c2");
    cyc();                                  // C3
    query(0, 5'd3, 1'b0, 1'b0, 32'h0, "post_reset_q3");

    // ALU write to $8.
    issue(3'd0, 3'd0, 5'd8, 5'd0, 32'h0);
    exp_wr(5'd8, 32'h0000_1234);
    cyc();                                  // C4: E
    bus.alu_res = 32'h0000_1234;
    query(0, 5'd8, 1'b0, 1'b1, 32'h0, "alu_in_e_wait");
    cyc();                                  // C5: M
    bus.alu_res = 32'h0000_0BAD;
    query(0, 5'd8, 1'b1, 1'b0, 32'h0000_1234, "alu_in_m_fwd");
    cyc();                                  // C6: W
    query(0, 5'd8, 1'b1, 1'b0, 32'h0000_1234, "alu_in_w_fwd");

    // Load to $9.
    issue(3'd0, 3'd1, 5'd9, 5'd0, 32'h0);
    exp_wr(5'd9, 32'hDEAD_BEEF);
    cyc();                                  // C7: E
    bus.alu_res = 32'h0000_0055;
    query(1, 5'd9, 1'b0, 1'b1, 32'h0, "load_in_e_wait");
    cyc();                                  // C8: M
    bus.load_data = 32'hDEAD_BEEF;
    query(1, 5'd9, 1'b0, 1'b1, 32'h0, "load_in_m_wait");
    cyc();                                  // C9: W
    bus.load_data = 32'h0;
    query(1, 5'd9, 1'b1, 1'b0, 32'hDEAD_BEEF, "load_in_w_fwd");

    // Link write to $31.
    issue(3'd2, 3'd2, 5'd0, 5'd0, 32'h0000_3000);
    exp_wr(5'd31, 32'h0000_3008);
    cyc();                                  // C10: E
    bus.alu_res = 32'h0000_FFFF;
    query(0, 5'd31, 1'b1, 1'b0, 32'h0000_3008, "link_in_e_fwd");
    cyc();                                  // C11: M
    query(0, 5'd31, 1'b1, 1'b0, 32'h0000_3008, "link_in_m_fwd");
    cyc();                                  // C12: W

    // Priority: ALU $5=0x11 (via rd) followed by a load to $5.
    issue(3'd1, 3'd0, 5'd0, 5'd5, 32'h0);
    exp_wr(5'd5, 32'h0000_0011);
    cyc();                                  // C13: E=alu5
    bus.alu_res = 32'h0000_0011;
    issue(3'd0, 3'd1, 5'd5, 5'd0, 32'h0);
    exp_wr(5'd5, 32'h0000_0077);
    query(0, 5'd5, 1'b0, 1'b1, 32'h0, "prio_alu5_e");
    cyc();                                  // C14: E=load5 M=alu5
    query(0, 5'd5, 1'b0, 1'b1, 32'h0, "prio_load_e_hides_m");
    cyc();                                  // C15: M=load5 W=alu5
    bus.load_data = 32'h0000_0077;
    query(1, 5'd5, 1'b0, 1'b1, 32'h0, "prio_load_m_hides_w");
    cyc();                                  // C16: W=load5
    bus.load_data = 32'h0;
    query(1, 5'd5, 1'b1, 1'b0, 32'h0000_0077, "prio_load_w_fwd");

    // Writes that target $0 or carry no result.
    issue(3'd0, 3'd0, 5'd0, 5'd0, 32'h0);
    cyc();                                  // C17
    bus.alu_res = 32'h0000_0099;
    issue(3'd3, 3'd0, 5'd6, 5'd6, 32'h0);
    query(0, 5'd0, 1'b0, 1'b0, 32'h0, "zero_q0");
    query(1, 5'd6, 1'b0, 1'b0, 32'h0, "nowrite_q6_a");
    cyc();                                  // C18
    bus.alu_res = 32'h0000_0098;
    issue(3'd1, 3'd3, 5'd0, 5'd6, 32'h0);
    query(0, 5'd0, 1'b0, 1'b0, 32'h0, "zero_q0_b");
    query(1, 5'd6, 1'b0, 1'b0, 32'h0, "rdst3_q6");
    cyc();                                  // C19
    query(1, 5'd6, 1'b0, 1'b0, 32'h0, "wsel3_q6");

    // Kill: ALU write to $7 flushed while in E.
    issue(3'd0, 3'd0, 5'd7, 5'd0, 32'h0);
    cyc();                                  // C20: E=$7
    bus.flush   = 1'b1;
    bus.alu_res = 32'h0000_7777;
    query(0, 5'd7, 1'b0, 1'b1, 32'h0, "kill_before_edge");
    cyc();                                  // C21
    query(0, 5'd7, 1'b0, 1'b0, 32'h0, "kill_after_edge");
    cyc();                                  // C22
    query(0, 5'd7, 1'b0, 1'b0, 32'h0, "kill_after_edge_2");

    // stall + flush together: E and M both become bubbles.
    issue(3'd0, 3'd0, 5'd10, 5'd0, 32'h0);
    cyc();                                  // C23: E=$10
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    issue(3'd2, 3'd2, 5'd0, 5'd0, 32'h0000_4000);
    query(1, 5'd10, 1'b0, 1'b1, 32'h0, "sf_before_edge");
    cyc();                                  // C24
    query(1, 5'd10, 1'b0, 1'b0, 32'h0, "sf_killed_m");
    query(0, 5'd31, 1'b0, 1'b0, 32'h0, "sf_dropped_e");
    cyc();                                  // C25
    query(1, 5'd10, 1'b0, 1'b0, 32'h0, "sf_killed_m_2");

    // Stall alone drops the offered instruction.
    bus.stall = 1'b1;
    issue(3'd2, 3'd2, 5'd0, 5'd0, 32'h0000_5000);
    cyc();                                  // C26
    query(0, 5'd31, 1'b0, 1'b0, 32'h0, "stall_dropped");

    // Flush alone does not stop a new instruction entering E.
    bus.flush = 1'b1;
    issue(3'd2, 3'd2, 5'd0, 5'd0, 32'h0000_6000);
    exp_wr(5'd31, 32'h0000_6008);
    cyc();                                  // C27: E=link
    query(0, 5'd31, 1'b1, 1'b0, 32'h0000_6008, "flush_entry_kept");
    cyc();                                  // C28
    cyc();                                  // C29: W=link

    // Three writes in flight, then reset.
    issue(3'd0, 3'd0, 5'd11, 5'd0, 32'h0);
    exp_wr(5'd11, 32'h0000_1111);
    cyc();                                  // C30: E=$11
    bus.alu_res = 32'h0000_1111;
    issue(3'd0, 3'd1, 5'd12, 5'd0, 32'h0);
    cyc();                                  // C31: E=load12 M=$11
    bus.alu_res = 32'h0000_2222;
    issue(3'd2, 3'd2, 5'd0, 5'd0, 32'h0000_7000);
    cyc();                                  // C32: E=link M=load12 W=$11
    bus.load_data = 32'h0000_1212;
    query(0, 5'd12, 1'b0, 1'b1, 32'h0, "inflight_load12");
    query(1, 5'd31, 1'b1, 1'b0, 32'h0000_7008, "inflight_link");
    reset = 1'b1;
    cyc();                                  // C33
    reset = 1'b0;
    query(0, 5'd12, 1'b0, 1'b0, 32'h0, "midreset_q12");
    query(1, 5'd31, 1'b0, 1'b0, 32'h0, "midreset_q31");
    cyc();                                  // C34
    query(0, 5'd11, 1'b0, 1'b0, 32'h0, "midreset_q11");
    cyc();                                  // C35
    cyc();                                  // C36
    cyc();                                  // C37

    // Everything promised must have shown up.
    n_checks++;
    if (rf_q.size() != 0) begin
      n_fails++;
      $display("FAIL rf_pending: got %0d outstanding writes, required 0", rf_q.size());
    end
    n_checks++;
    if (qx_q.size() != 0) begin
      n_fails++;
      $display("FAIL query_pending: got %0d outstanding queries, required 0", qx_q.size());
    end
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got no end of stimulus, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_forward_pipe.md
# wb_forward_pipe

Parametrised write-back pipeline for the pipelined MIPS datapath. It takes decoded destination and result-source selects at the start of the E stage and carries each instruction's write address and data through the E, M and W stage registers. Result data is captured in whichever stage produces it, and the block drives the GRF write port from W. It also provides a bypass network with per-operand forward and wait outputs that feed the D-stage operand muxes and the hazard unit.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- LINK_REG, 31, destination for reg_dst==2
- LINK_OFF, 8, added to pc for wsel==2 (delay slot)
- NQ, 2, number of bypass query ports

- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  decoded instruction present for entry into E
- stall  in  1  force a bubble into E this edge
- flush  in  1  kill the instruction currently in E
- reg_dst  in  3  0 rt, 1 rd, 2 LINK_REG, 3-7 no write
- wsel  in  3  0 ALU, 1 load, 2 pc+LINK_OFF, 3-7 no write
- rt, rd  in  ADDR_W  instruction fields
- pc  in  DATA_W  PC of entering instruction
- alu_res  in  DATA_W  ALU result of the instruction in E
- load_data  in  DATA_W  memory read data of the instruction in M
- q_addr  in  NQ*ADDR_W  packed query addresses, port i at [i*ADDR_W +: ADDR_W]
- q_data  out  NQ*DATA_W  forwarded value per port
- q_fwd  out  NQ  forwarded value valid
- q_wait  out  NQ  youngest matching producer not ready
- rf_we  out  1  GRF write enable
- rf_waddr  out  ADDR_W  GRF write address
- rf_wdata  out  DATA_W  GRF write data

## Operation
- Each stage register S in {E,M,W} holds: v, addr, sel, data, rdy.
- Entry into E: if in_valid & !stall, load addr, sel, data and rdy. Otherwise load a bubble (v=0).
  - addr = rt / rd / LINK_REG per reg_dst. addr = 0 for reg_dst≥3 or wsel≥3.
  - wsel==2: data = pc+LINK_OFF (mod 2^DATA_W), rdy=1. Otherwise data=0, rdy=0.
- E→M: if flush, M gets a bubble. Otherwise copy. If E.sel==0, data=alu_res and rdy=1.
- M→W: copy. If M.sel==1, data=load_data and rdy=1.
- A stage "writes" iff v=1 and addr≠0.
- rf_we = W writes; rf_waddr = W.addr; rf_wdata = W.data. All three are 0 when W does not write.
- Bypass, per port i, combinational:
  - Search stages E, M, W, youngest first. The first writing stage with addr==q_addr[i] is the match.
  - Match with rdy=1: q_fwd=1, q_data=match data, q_wait=0.
  - Match with rdy=0: q_fwd=0, q_wait=1, q_data=0.
  - No match, or q_addr==0: all three outputs 0.
  - An older ready match never hides a younger not-ready one.
- load_data is never bypassed combinationally. A load in M reports wait.
- stall and flush together: E gets a bubble and M gets a bubble.
- All stage registers advance every non-reset edge. There is no global freeze.

## Timing
- Reset: all v=0, all stage fields 0. rf_we=0, rf_waddr=0, rf_wdata=0, q_* =0 from the first edge with reset high.
- Reset mid-flight discards every in-flight write. No rf_we is asserted for pre-reset instructions.
- Instruction accepted at edge t: occupies E during cycle t..t+1, M at t+1, W at t+2. rf_we is high during cycle t+2..t+3.
- Forward availability after acceptance at edge t:
  - pc-link: from cycle t (in E).
  - ALU: from cycle t+1 (in M).
  - load: from cycle t+2 (in W).
- q_* outputs are purely combinational from the stage registers and q_addr. There is no path from alu_res or load_data to q_*.
- rf_* outputs are registered, with no combinational input path.

## Test plan
- Reset held 2 cycles with in_valid=1 → rf_we=0, rf_waddr=0, rf_wdata=0, q_wait=0, q_fwd=0 throughout and one cycle after release.
- ALU write: reg_dst=0, rt=8, wsel=0, alu_res=0x00001234 → next cycle q_addr=8 gives q_fwd=1, q_data=0x1234. Two cycles later rf_we=1, rf_waddr=8, rf_wdata=0x1234.
- Load: reg_dst=0, rt=9, wsel=1, load_data=0xDEADBEEF while in M → q_addr=9 gives q_wait=1 in E and in M, then q_fwd=1 with 0xDEADBEEF in W. rf write lands on $9.
- Link: reg_dst=2, wsel=2, pc=0x00003000 → same cycle q_addr=31 gives q_fwd=1, q_data=0x00003008. Later rf_waddr=31, rf_wdata=0x3008.
- Priority and $0:
  - ALU write $5=0x11, then a load to $5 → query $5 gives q_wait=1, not 0x11.
  - Write to $0 → rf_we=0; query 0 gives q_fwd=0, q_wait=0.
- Kill: accept an ALU write to $7 and assert flush the next cycle → no rf_we for $7, and q_addr=7 gives no match after that edge.
- Stall: stall=1 with in_valid=1 → that instruction is dropped (bubble).
- Reset asserted with three writes in flight → no rf_we after the reset edge.
